// File: rtl/gated_reg_checker_pkg.sv
// Shared state encoding and default sizing for the gated register checker.
package gated_reg_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int CNT_W_DEF     = 8;
  localparam int CYC_W_DEF     = 16;
  localparam int ERR_LIMIT_DEF = 255;

endpackage

// File: rtl/gated_reg_model.sv
// Behavioural reference of the observed gated register: exp = enable ? a : ~a, one stage.
// Free-running every cycle; only reset clears it.
module gated_reg_model
  import gated_reg_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic a_i,
  output logic exp_q_o
);

  logic exp_d;
  logic exp_q;

  assign exp_d = enable_i ? a_i : ~a_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_q_o = exp_q;

endmodule

// File: rtl/gated_reg_checker.sv
// Compares an observed gated register against a one-stage reference model while armed.
// Counts mismatches, records the cycle of the first one, and halts at ERR_LIMIT.
module gated_reg_checker
  import gated_reg_checker_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int CYC_W     = CYC_W_DEF,
  parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_start,
  input  logic             chk_stop,
  input  logic             enable,
  input  logic             a,
  input  logic             out,
  output logic             busy,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CYC_W-1:0] first_err_cyc,
  output logic             halted
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ERR_LIMIT);
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  state_t           state_q;
  logic             busy_q;
  logic             halted_q;
  logic             exp_q;
  logic             start_go;
  logic             mismatch;
  logic             limit_hit;
  logic [CYC_W-1:0] cycle_cnt_d,     cycle_cnt_q;
  logic [CNT_W-1:0] err_count_d,     err_count_q;
  logic             err_flag_d,      err_flag_q;
  logic [CYC_W-1:0] first_err_cyc_d, first_err_cyc_q;

  gated_reg_model u_model (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .a_i      (a),
    .exp_q_o  (exp_q)
  );

  assign start_go = (state_q == ST_IDLE) && chk_start;
  assign mismatch = (state_q == ST_CHECK) && (out != exp_q);

  always_comb begin
    cycle_cnt_d     = cycle_cnt_q;
    err_count_d     = err_count_q;
    err_flag_d      = err_flag_q;
    first_err_cyc_d = first_err_cyc_q;
    if (start_go) begin
      cycle_cnt_d     = '0;
      err_count_d     = '0;
      err_flag_d      = 1'b0;
      first_err_cyc_d = '0;
    end else begin
      if ((state_q == ST_CHECK) && (cycle_cnt_q != CYC_MAX)) begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
      end
      // In CHECK err_count is always below LIMIT, so the increment cannot overshoot.
      if (mismatch) begin
        err_count_d = err_count_q + 1'b1;
        err_flag_d  = 1'b1;
        if (!err_flag_q) begin
          first_err_cyc_d = cycle_cnt_q;
        end
      end
    end
  end

  assign limit_hit = mismatch && (err_count_d == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q     <= '0;
      err_count_q     <= '0;
      err_flag_q      <= 1'b0;
      first_err_cyc_q <= '0;
    end else begin
      cycle_cnt_q     <= cycle_cnt_d;
      err_count_q     <= err_count_d;
      err_flag_q      <= err_flag_d;
      first_err_cyc_q <= first_err_cyc_d;
    end
  end

  // chk_stop takes priority over reaching the limit: the mismatch still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (chk_start) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (chk_stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (limit_hit) begin
            state_q  <= ST_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (chk_stop) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign halted        = halted_q;
  assign err_flag      = err_flag_q;
  assign err_count     = err_count_q;
  assign first_err_cyc = first_err_cyc_q;

endmodule
